// File: rtl/wb_master_bridge.sv
// wb_master_bridge: turns a valid/ready request port into single Wishbone
// classic transactions, one outstanding at a time, with a bus timeout, an
// error response and a saturating error counter.
module wb_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int SEL_WIDTH      = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ERR_CNT_WIDTH  = 16
) (
  input  logic                     clk_core,
  input  logic                     rst_core,
  // request / response port
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  input  logic [SEL_WIDTH-1:0]     req_sel,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  // Wishbone classic master
  output logic                     wb_cyc,
  output logic                     wb_stb,
  output logic                     wb_we,
  output logic [SEL_WIDTH-1:0]     wb_sel,
  output logic [ADDR_WIDTH-1:0]    wb_adr,
  output logic [DATA_WIDTH-1:0]    wb_dat_o,
  input  logic [DATA_WIDTH-1:0]    wb_dat_i,
  input  logic                     wb_ack,
  input  logic                     wb_err,
  // status
  output logic [ERR_CNT_WIDTH-1:0] err_count
);

  // The counter only has to reach TIMEOUT_CYCLES-1 before the bus is abandoned.
  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;
  logic            accept;    // handshake this cycle
  logic            bus_done;  // transaction ends this cycle
  logic            bus_fail;  // ...and ends as an error

  assign req_ready   = (state == IDLE);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

  // Next-state decode; a slave reply always beats a coinciding timeout.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next = state;
    accept     = 1'b0;
    bus_done   = 1'b0;
    bus_fail   = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = BUS;
        end
      end
      BUS: begin
        if (wb_err || wb_ack || timeout_hit) begin
          bus_done   = 1'b1;
          // wb_err wins over wb_ack; without either, the timeout fired.
          bus_fail   = wb_err || !wb_ack;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_core) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst_core) state <= IDLE;
    else          state <= state_next;
  end

  // Registered Wishbone framing, response capture, timeout and error counter.
  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_we      <= 1'b0;
      wb_sel     <= '0;
      wb_adr     <= '0;
      wb_dat_o   <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      err_count  <= '0;
      to_cnt     <= '0;
    end else begin
      // resp_valid is a single-cycle pulse: it is only set on leaving BUS.
      resp_valid <= 1'b0;

      if (state == BUS) to_cnt <= to_cnt + TO_W'(1);

      if (accept) begin
        wb_cyc   <= 1'b1;
        wb_stb   <= 1'b1;
        wb_we    <= req_we;
        wb_sel   <= req_sel;
        wb_adr   <= req_addr;
        wb_dat_o <= req_wdata;
        to_cnt   <= '0;
      end

      if (bus_done) begin
        wb_cyc     <= 1'b0;
        wb_stb     <= 1'b0;
        resp_valid <= 1'b1;
        resp_err   <= bus_fail;
        resp_rdata <= (bus_fail || wb_we) ? '0 : wb_dat_i;
        if (bus_fail && (err_count != '1))
          err_count <= err_count + ERR_CNT_WIDTH'(1);
      end
    end
  end

endmodule
